// File: rtl/reg_vec_pkg.sv
// Shared helpers for the reg_vec register-bank pipeline: lane slicing and count width.
package reg_vec_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Returns lane k of a flat lane-packed vector, zero-extended; caller truncates to w bits.
    function automatic logic [1023:0] lane_sel(input logic [1023:0] bits, input int k, input int w);
        logic [1023:0] m;
        m = ~({1024{1'b1}} << w);
        return (bits >> (k * w)) & m;
    endfunction

endpackage

// File: rtl/reg_vec_stage.sv
// One elastic pipeline slot: a valid bit plus the full vector word it carries.
module reg_vec_stage #(
    parameter int BW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [BW-1:0] in_bits,
    input  logic          move_in,
    input  logic          move_out,
    output logic          valid,
    output logic [BW-1:0] data
);

    // Data loads only for a real word arriving, so bubbles leave the previous word in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (move_in || move_out) begin
            valid <= in_valid && move_in;
            if (move_in && in_valid) data <= in_bits;
        end
    end

endmodule

// File: rtl/reg_vec_pipe.sv
// LANES x WIDTH register vector through a DEPTH-stage elastic pipe with per-lane write mask,
// flush and occupancy count.
module reg_vec_pipe
    import reg_vec_pkg::*;
#(
    parameter int LANES = 2,
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      io_in_valid,
    output logic                      io_in_ready,
    input  logic [LANES*WIDTH-1:0]    io_in_bits,
    input  logic [LANES-1:0]          io_in_mask,
    input  logic                      io_flush,
    output logic                      io_out_valid,
    input  logic                      io_out_ready,
    output logic [LANES*WIDTH-1:0]    io_out_bits,
    output logic [cnt_w(DEPTH)-1:0]   io_count
);

    localparam int BW = LANES * WIDTH;
    localparam int CW = cnt_w(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("reg_vec_pipe: DEPTH must be >= 1");
    end

    logic [DEPTH-1:0]         valid, move, up_valid, up_move;
    logic [DEPTH-1:0][BW-1:0] data, up_bits;
    logic [BW-1:0]            last, merged;
    logic                     accept;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign merged[k*WIDTH +: WIDTH] = io_in_mask[k]
            ? WIDTH'(lane_sel(1024'(io_in_bits), k, WIDTH))
            : last[k*WIDTH +: WIDTH];
    end

    assign accept = io_in_valid && io_in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    last <= '0;
        else if (accept) last <= merged;
    end

    // A stage can advance if the output is draining or any later stage has a hole;
    // this is the unrolled form of move[i] = !valid[i+1] | move[i+1].
    for (genvar i = 0; i < DEPTH; i++) begin : g_move
        if (i == DEPTH - 1) begin : g_tail
            assign move[i] = io_out_ready;
        end else begin : g_body
            assign move[i] = io_out_ready || !(&valid[DEPTH-1:i+1]);
        end
    end

    assign io_in_ready = (!valid[0] || move[0]) && !io_flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign up_valid[i] = io_in_valid;
            assign up_move[i]  = io_in_ready;
            assign up_bits[i]  = merged;
        end else begin : g_link
            assign up_valid[i] = valid[i-1];
            assign up_move[i]  = move[i-1];
            assign up_bits[i]  = data[i-1];
        end

        reg_vec_stage #(.BW(BW)) u_stage (
            .clk      (clk),
            .rst_n    (reset_n),
            .flush    (io_flush),
            .in_valid (up_valid[i]),
            .in_bits  (up_bits[i]),
            .move_in  (up_move[i]),
            .move_out (move[i]),
            .valid    (valid[i]),
            .data     (data[i])
        );
    end

    always_comb begin
        io_count = '0;
        for (int i = 0; i < DEPTH; i++) io_count = io_count + CW'(valid[i]);
    end

    // Output handshake is suppressed while flushing so the consumer never takes a dropped word.
    assign io_out_valid = valid[DEPTH-1] && !io_flush;
    assign io_out_bits  = data[DEPTH-1];

endmodule
